// File: rtl/chesssoc_ocimem_pkg.sv
// -----------------------------------------------------------------------------
// chesssoc_ocimem_pkg
// Shared definitions for the debug OCIMEM controller:
//   - controller FSM state encoding
//   - bit positions of the fields inside the 38-bit jdo command word
//   - data returned to the CPU on a parity failure
//   - small word helpers (parity, byte-lane merge)
// Optional feature macro used by the importers: OCIMEM_PARITY_EN.
// -----------------------------------------------------------------------------
package chesssoc_ocimem_pkg;

   // ST_CRMW is only reached when OCIMEM_PARITY_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRD  = 2'd1,
      ST_CRD  = 2'd2,
      ST_CRMW = 2'd3
   } ocimem_state_e;

   localparam int unsigned JDO_CLR_ERR     = 35;
   localparam int unsigned JDO_RD_AFTER_LD = 34;
   localparam int unsigned JDO_ADDR_LSB    = 17;
   localparam int unsigned JDO_WDATA_LSB   = 3;

   localparam logic [31:0] PARITY_ERR_DATA = 32'hDEAD_BEEF;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

   function automatic logic parity_ok(input logic [32:0] w);
      return w[32] == even_parity(w[31:0]);
   endfunction

   // Byte lanes with be set come from new_d, the rest from old_d.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                               input logic [31:0] new_d,
                                               input logic [3:0]  be);
      logic [31:0] m;
      m = old_d;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) m[8*i +: 8] = new_d[8*i +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/chesssoc_ocimem_ram.sv
// -----------------------------------------------------------------------------
// chesssoc_ocimem_ram
// Single-port synchronous RAM, 2^ADDR_W words of DATA_W bits, read-first,
// registered read data (one cycle latency). Bits [31:0] are written per byte
// lane under be; any bits above 31 are written whenever any lane is enabled.
// Ports:
//   clk    - clock
//   addr   - word address
//   we     - write enable
//   be     - byte-lane enables for bits [31:0]
//   wdata  - write data
//   q      - registered read data of the word addressed in the previous cycle
// -----------------------------------------------------------------------------
module chesssoc_ocimem_ram #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] bit_mask;

   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < DATA_W; i++) begin
         bit_mask[i] = (i < 32) ? be[i/8] : |be;
      end
   end

   // NOTE: the array has no reset branch so it maps onto real RAM macros;
   // its contents are simply undefined until written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= (mem[addr] & ~bit_mask) | (wdata & bit_mask);
      end
      q <= mem[addr];
   end

endmodule

// File: rtl/chesssoc_debug_ocimem_ctrl.sv
// -----------------------------------------------------------------------------
// chesssoc_debug_ocimem_ctrl
// Debug-side on-chip memory controller behind the Nios II debug-slave wrapper.
// JTAG command pulses (with the jdo word) load an address register, write or
// read the local debug RAM and report through MonDReg / monitor_ready /
// monitor_error. The same RAM is shared with the CPU over an Avalon-MM slave;
// JTAG always wins and the CPU is stalled with waitrequest.
// Optional feature: define OCIMEM_PARITY_EN for a 33-bit RAM with even parity
// (partial CPU writes become read-modify-write, parity errors are reported).
// Ports:
//   clk, reset_n                  - clock, async active-low reset
//   jdo                           - command word from the debug slave
//   take_action_ocimem_a          - load address (optionally read)
//   take_action_ocimem_b          - write data at MonAReg
//   take_no_action_ocimem_a       - read next word at MonAReg
//   MonDReg                       - debug data register
//   monitor_ready, monitor_error  - command done / sticky error
//   avalon_*                      - CPU slave port (word addressed)
// -----------------------------------------------------------------------------
module chesssoc_debug_ocimem_ctrl
   import chesssoc_ocimem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter bit          INIT_READY = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   input  logic [ADDR_W-1:0] avalon_address,
   input  logic              avalon_read,
   input  logic              avalon_write,
   input  logic [31:0]       avalon_writedata,
   input  logic [3:0]        avalon_byteenable,
   output logic [31:0]       avalon_readdata,
   output logic              avalon_waitrequest
);

`ifdef OCIMEM_PARITY_EN
   localparam int unsigned RAM_W = 33;
`else
   localparam int unsigned RAM_W = 32;
`endif

   ocimem_state_e     state, state_n;
   logic [ADDR_W-1:0] mon_areg;
   logic [31:0]       rdata_q;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [3:0]        ram_be;
   logic [RAM_W-1:0]  ram_wdata;
   logic [RAM_W-1:0]  ram_q;

   logic [ADDR_W-1:0] jdo_addr;
   logic [31:0]       jdo_wdata;
   logic              any_pulse, multi_pulse, is_idle;
   logic              cmd_a, cmd_b, cmd_n, dbg_read, cpu_req;
   logic [31:0]       cpu_rd_data;
   logic              unused_jdo_bits;

   assign jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
   assign jdo_wdata = jdo[JDO_WDATA_LSB +: 32];
   assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

   function automatic logic [RAM_W-1:0] pack_word(input logic [31:0] d);
`ifdef OCIMEM_PARITY_EN
      return {even_parity(d), d};
`else
      return d;
`endif
   endfunction

   // Command decode: only one command executes per cycle, b > a > no_action,
   // and nothing executes outside IDLE.
   assign any_pulse   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign multi_pulse = (take_action_ocimem_a & take_action_ocimem_b)
                      | (take_action_ocimem_a & take_no_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a);
   assign is_idle     = (state == ST_IDLE);
   assign cmd_b       = is_idle & take_action_ocimem_b;
   assign cmd_a       = is_idle & take_action_ocimem_a & ~take_action_ocimem_b;
   assign cmd_n       = is_idle & take_no_action_ocimem_a
                      & ~take_action_ocimem_a & ~take_action_ocimem_b;
   assign dbg_read    = (cmd_a & jdo[JDO_RD_AFTER_LD]) | cmd_n;
   assign cpu_req     = avalon_read | avalon_write;

`ifdef OCIMEM_PARITY_EN
   assign cpu_rd_data = parity_ok(ram_q) ? ram_q[31:0] : PARITY_ERR_DATA;
`else
   assign cpu_rd_data = ram_q[31:0];
`endif

   // RAM output is already valid in CRD, so the CPU sees it in the same
   // cycle waitrequest drops; the register holds it afterwards.
   assign avalon_readdata = (state == ST_CRD) ? cpu_rd_data : rdata_q;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_n            = state;
      avalon_waitrequest = 1'b0;
      ram_addr           = avalon_address;
      ram_we             = 1'b0;
      ram_be             = 4'hF;
      ram_wdata          = pack_word(avalon_writedata);

      case (state)
         ST_IDLE: begin
            if (any_pulse) begin
               avalon_waitrequest = cpu_req;
               if (take_action_ocimem_b) begin
                  ram_addr  = mon_areg;
                  ram_we    = 1'b1;
                  ram_wdata = pack_word(jdo_wdata);
               end else if (take_action_ocimem_a) begin
                  ram_addr = jdo_addr;
               end else begin
                  ram_addr = mon_areg;
               end
               if (dbg_read) state_n = ST_DRD;
            end else if (avalon_write) begin
`ifdef OCIMEM_PARITY_EN
               // Partial writes fetch the old word first so parity covers
               // the merged result.
               if (avalon_byteenable != 4'hF) begin
                  avalon_waitrequest = 1'b1;
                  state_n            = ST_CRMW;
               end else begin
                  ram_we = 1'b1;
               end
`else
               ram_we = 1'b1;
               ram_be = avalon_byteenable;
`endif
            end else if (avalon_read) begin
               avalon_waitrequest = 1'b1;
               state_n            = ST_CRD;
            end
         end
         ST_DRD: begin
            avalon_waitrequest = cpu_req;
            state_n            = ST_IDLE;
         end
         ST_CRD: begin
            state_n = ST_IDLE;
         end
`ifdef OCIMEM_PARITY_EN
         ST_CRMW: begin
            ram_we    = 1'b1;
            ram_wdata = pack_word(merge_bytes(ram_q[31:0], avalon_writedata,
                                              avalon_byteenable));
            state_n   = ST_IDLE;
         end
`endif
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // NOTE: state elements use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mon_areg      <= '0;
         MonDReg       <= '0;
         monitor_ready <= INIT_READY;
         monitor_error <= 1'b0;
         rdata_q       <= '0;
      end else begin
         // A clear request loses against an error raised in the same cycle.
         if (cmd_a && jdo[JDO_CLR_ERR]) monitor_error <= 1'b0;
         if (multi_pulse || (any_pulse && !is_idle)) monitor_error <= 1'b1;
`ifdef OCIMEM_PARITY_EN
         if (state == ST_DRD && !parity_ok(ram_q)) monitor_error <= 1'b1;
`endif

         if (cmd_b) begin
            mon_areg      <= mon_areg + 1'b1;
            MonDReg       <= jdo_wdata;
            monitor_ready <= 1'b1;
         end
         if (cmd_a) begin
            // A read-after-load consumes the word, so the pointer moves on
            // to the next one just like a no_action read.
            mon_areg      <= jdo[JDO_RD_AFTER_LD] ? jdo_addr + 1'b1 : jdo_addr;
            monitor_ready <= ~jdo[JDO_RD_AFTER_LD];
         end
         if (cmd_n) begin
            mon_areg      <= mon_areg + 1'b1;
            monitor_ready <= 1'b0;
         end
         if (state == ST_DRD) begin
            MonDReg       <= ram_q[31:0];
            monitor_ready <= 1'b1;
         end
         if (state == ST_CRD) rdata_q <= cpu_rd_data;
      end
   end

   // Writes are gated by reset so an aborted access cannot land in the RAM.
   chesssoc_ocimem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (RAM_W)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we & reset_n),
      .be    (ram_be),
      .wdata (ram_wdata),
      .q     (ram_q)
   );

endmodule

// File: tb/tb_chesssoc_debug_ocimem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chesssoc_debug_ocimem_ctrl
// Directed bench for the debug OCIMEM controller (ADDR_W=8, INIT_READY=0).
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after
// the rising edge, well away from the next one.
// -----------------------------------------------------------------------------
module tb_chesssoc_debug_ocimem_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;
   logic [7:0]  avalon_address;
   logic        avalon_read, avalon_write;
   logic [31:0] avalon_writedata;
   logic [3:0]  avalon_byteenable;
   logic [31:0] avalon_readdata;
   logic        avalon_waitrequest;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] rd;
   int          waits;

   always #5 clk = ~clk;

   chesssoc_debug_ocimem_ctrl #(
      .ADDR_W     (8),
      .INIT_READY (1'b0)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .avalon_address          (avalon_address),
      .avalon_read             (avalon_read),
      .avalon_write            (avalon_write),
      .avalon_writedata        (avalon_writedata),
      .avalon_byteenable       (avalon_byteenable),
      .avalon_readdata         (avalon_readdata),
      .avalon_waitrequest      (avalon_waitrequest)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] jdo_a(input logic clr, input logic rd_ld, input logic [7:0] addr);
      logic [37:0] j;
      j        = '0;
      j[35]    = clr;
      j[34]    = rd_ld;
      j[24:17] = addr;
      return j;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] d);
      logic [37:0] j;
      j      = '0;
      j[34:3] = d;
      return j;
   endfunction

   task automatic pulse_a(input logic clr, input logic rd_ld, input logic [7:0] addr);
      jdo = jdo_a(clr, rd_ld, addr);
      take_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0;
   endtask

   task automatic pulse_b(input logic [31:0] d);
      jdo = jdo_b(d);
      take_action_ocimem_b = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
   endtask

   task automatic pulse_n();
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] addr, output logic [31:0] data, output int w);
      logic granted;
      granted = 1'b0;
      data    = 'x;
      w       = 0;
      avalon_address = addr;
      avalon_read    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (!avalon_waitrequest) begin
            data    = avalon_readdata;
            granted = 1'b1;
            break;
         end
         w++;
         tick();
      end
      check("cpu_read_granted", granted, 1'b1);
      tick();
      avalon_read = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] addr, input logic [31:0] d,
                            input logic [3:0] be, output int w);
      logic granted;
      granted = 1'b0;
      w       = 0;
      avalon_address    = addr;
      avalon_writedata  = d;
      avalon_byteenable = be;
      avalon_write      = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (!avalon_waitrequest) begin
            granted = 1'b1;
            break;
         end
         w++;
         tick();
      end
      check("cpu_write_granted", granted, 1'b1);
      tick();
      avalon_write      = 1'b0;
      avalon_byteenable = 4'hF;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n                 = 1'b0;
      jdo                     = '0;
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      avalon_address          = '0;
      avalon_read             = 1'b0;
      avalon_write            = 1'b0;
      avalon_writedata        = '0;
      avalon_byteenable       = 4'hF;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      check("rst_mondreg", MonDReg, 32'h0);
      check("rst_ready", monitor_ready, 1'b0);
      check("rst_error", monitor_error, 1'b0);
      check("rst_waitreq", avalon_waitrequest, 1'b0);
      check("rst_readdata", avalon_readdata, 32'h0);

      // Load address 0x10 without read, then write two words
      pulse_a(1'b0, 1'b0, 8'h10);
      check("load_ready", monitor_ready, 1'b1);
      pulse_b(32'hCAFEF00D);
      check("wr_ready", monitor_ready, 1'b1);
      check("wr_mondreg", MonDReg, 32'hCAFEF00D);
      pulse_b(32'h11111111);
      cpu_read(8'h10, rd, waits);
      check("cpu_rd_10", rd, 32'hCAFEF00D);
      check("cpu_rd_waits", waits, 1);
      cpu_read(8'h11, rd, waits);
      check("cpu_rd_11", rd, 32'h11111111);

      // Read-after-load at 0x10: ready low at t+1, high at t+2
      pulse_a(1'b0, 1'b1, 8'h10);
      check("ral_ready_t1", monitor_ready, 1'b0);
      tick();
      check("ral_ready_t2", monitor_ready, 1'b1);
      check("ral_mondreg", MonDReg, 32'hCAFEF00D);

      // no_action reads 0x11, pointer moves to 0x12
      pulse_n();
      check("nxt_ready_t1", monitor_ready, 1'b0);
      tick();
      check("nxt_ready_t2", monitor_ready, 1'b1);
      check("nxt_mondreg", MonDReg, 32'h11111111);
      pulse_b(32'hA5A5A5A5);
      cpu_read(8'h12, rd, waits);
      check("ptr_0x12", rd, 32'hA5A5A5A5);

      // CPU byte-masked write on lanes 0-1
      cpu_write(8'h12, 32'h0000BEEF, 4'b0011, waits);
`ifdef OCIMEM_PARITY_EN
      check("cpu_pwr_waits", waits, 1);
`else
      check("cpu_pwr_waits", waits, 0);
`endif
      cpu_read(8'h12, rd, waits);
      check("cpu_pwr_data", rd, 32'hA5A5BEEF);

      // Address wrap 0xFF -> 0x00
      pulse_a(1'b0, 1'b0, 8'hFF);
      pulse_b(32'h0F0F0F0F);
      pulse_b(32'h76543210);
      cpu_read(8'hFF, rd, waits);
      check("wrap_ff", rd, 32'h0F0F0F0F);
      cpu_read(8'h00, rd, waits);
      check("wrap_00", rd, 32'h76543210);

      // CPU read held while a JTAG write to the same word arrives
      pulse_a(1'b0, 1'b0, 8'h00);
      avalon_address       = 8'h00;
      avalon_read          = 1'b1;
      jdo                  = jdo_b(32'h13579BDF);
      take_action_ocimem_b = 1'b1;
      #1;
      check("cfl_wait_pulse", avalon_waitrequest, 1'b1);
      tick();
      take_action_ocimem_b = 1'b0;
      #1;
      check("cfl_wait_accept", avalon_waitrequest, 1'b1);
      tick();
      #1;
      check("cfl_wait_crd", avalon_waitrequest, 1'b0);
      check("cfl_data", avalon_readdata, 32'h13579BDF);
      tick();
      avalon_read = 1'b0;
      check("cfl_no_err", monitor_error, 1'b0);

      // Two pulses together: only the address load happens, error set
      jdo                     = jdo_a(1'b0, 1'b0, 8'h11);
      take_action_ocimem_a    = 1'b1;
      take_no_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_a    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      check("dbl_error", monitor_error, 1'b1);
      check("dbl_ready", monitor_ready, 1'b1);
      pulse_n();
      tick();
      check("dbl_load_only", MonDReg, 32'h11111111);
      pulse_a(1'b1, 1'b0, 8'h20);
      check("clr_error", monitor_error, 1'b0);

      // Pulse during DRD is ignored and flags an error
      pulse_a(1'b0, 1'b1, 8'h10);
      pulse_b(32'hDEAD0000);
      check("busy_error", monitor_error, 1'b1);
      check("busy_mondreg", MonDReg, 32'hCAFEF00D);
      cpu_read(8'h11, rd, waits);
      check("busy_no_write", rd, 32'h11111111);
      pulse_a(1'b1, 1'b0, 8'h10);
      check("clr_error2", monitor_error, 1'b0);

      // Reset during DRD aborts the read
      pulse_a(1'b0, 1'b1, 8'h11);
      reset_n = 1'b0;
      #1;
      check("mrst_mondreg", MonDReg, 32'h0);
      check("mrst_ready", monitor_ready, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      check("mrst_mondreg_after", MonDReg, 32'h0);
      check("mrst_waitreq", avalon_waitrequest, 1'b0);
      cpu_read(8'h10, rd, waits);
      check("mrst_ram_kept", rd, 32'hCAFEF00D);
      check("mrst_idle_waits", waits, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/chesssoc_debug_ocimem_ctrl.md
Name: chesssoc_debug_ocimem_ctrl

Overview:
- Debug-side on-chip memory (OCIMEM) controller directly downstream of the Nios II debug-slave wrapper.
- Consumes the wrapper's sysclk-domain command pulses and 38-bit `jdo` data word, and performs JTAG-initiated reads and writes into a local debug RAM.
- Returns MonDReg, monitor_ready and monitor_error back upstream to the wrapper's TCK side.
- Also exposes the same RAM to the CPU through an Avalon-MM slave port; JTAG always has priority.

Parameters:
- ADDR_W, 8, RAM word-address width; depth is 2^ADDR_W 32-bit words.
- INIT_READY, 0, reset value of monitor_ready.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  command data from the debug slave
- take_action_ocimem_a  in  1  1-cycle pulse: load address / optional read
- take_action_ocimem_b  in  1  1-cycle pulse: write data
- take_no_action_ocimem_a  in  1  1-cycle pulse: read next word
- MonDReg  out  32  debug data register
- monitor_ready  out  1  last debug command complete
- monitor_error  out  1  sticky command error
- avalon_address  in  ADDR_W  CPU word address
- avalon_read  in  1  CPU read request
- avalon_write  in  1  CPU write request
- avalon_writedata  in  32  CPU write data
- avalon_byteenable  in  4  CPU byte lanes
- avalon_readdata  out  32  CPU read data
- avalon_waitrequest  out  1  CPU stall

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset_n is asynchronous, active-low.
  - Reset clears MonAReg, MonDReg, monitor_error, avalon_readdata and avalon_waitrequest to 0; monitor_ready resets to INIT_READY; FSM resets to IDLE.
  - RAM contents are not reset.
  - Reset asserted mid-operation aborts any access; no partial write persists beyond the cycle it was issued.
- jdo fields:
  - [35] = clear_error.
  - [34] = read_after_load (ocimem_a).
  - [ADDR_W+16:17] = address.
  - [34:3] = write data (ocimem_b).
- Command pulses (accepted only in IDLE):
  - ocimem_a: MonAReg<=addr; if [35], monitor_error<=0; if [34], start debug read at addr, else monitor_ready<=1 next cycle.
  - ocimem_b: RAM[MonAReg]<=jdo[34:3] (all lanes) in the pulse cycle; MonDReg<=the same data; MonAReg<=MonAReg+1; monitor_ready<=1 at t+1.
  - no_action_ocimem_a: debug read at MonAReg; MonAReg<=MonAReg+1.
- Every accepted command clears monitor_ready in its pulse cycle.
- Debug read timing: RAM address is driven at t; FSM goes to DRD; q is valid in DRD (t+1) and is captured into MonDReg; monitor_ready=1 from t+2.
- Address arithmetic: MonAReg increments modulo 2^ADDR_W (all-ones wraps to 0).
- More than one pulse in the same cycle:
  - Execute only the highest priority, ocimem_b > ocimem_a > no_action.
  - Set monitor_error.
- Pulse arriving while not in IDLE: ignored; monitor_error<=1.
- FSM states: IDLE, DRD, CRD.
  - IDLE->DRD on a debug read.
  - IDLE->CRD on a CPU read with no debug pulse.
  - DRD->IDLE and CRD->IDLE after one cycle.
- CPU port:
  - Write: completes in one cycle (waitrequest=0) when IDLE and no debug pulse; byteenable masks lanes.
  - Read: waitrequest=1 in the accept cycle; data is registered into avalon_readdata in CRD with waitrequest=0. Latency is 1 wait state.
  - waitrequest=1 whenever the FSM is not IDLE or a debug pulse is present; the CPU request holds until granted.
  - A CPU request with both read and write set is treated as a write.

Optional Feature:
- Macro: OCIMEM_PARITY_EN.
- Defined:
  - RAM is widened to 33 bits; bit 32 holds the even parity of the data, computed on every write.
  - A CPU partial write recomputes parity over the merged word using a read-modify-write; this adds 1 wait state to byte-masked writes.
  - A debug read with a parity mismatch sets monitor_error; data is still returned.
  - A CPU read with a parity mismatch returns 32'hDEADBEEF.
- Undefined: 32-bit RAM, no checking, all writes single-cycle.

Decomposition:
- Package chesssoc_ocimem_pkg:
  - FSM state enum.
  - jdo field bit-position constants (JDO_CLR_ERR=35, JDO_RD_AFTER_LD=34, JDO_ADDR_LSB=17, JDO_WDATA_LSB=3).
  - Parity-error read constant.
- One sub-module: chesssoc_ocimem_ram, single-port synchronous RAM with per-byte write enables and registered output.
- Arbitration, FSM and MonAReg/MonDReg stay in the top module.

Test Plan:
- Load and read: ocimem_a with addr=0x10, [34]=0, then ocimem_b data 0xCAFEF00D -> RAM[0x10]=0xCAFEF00D, MonAReg=0x11, monitor_ready=1 one cycle after the write.
- Read-after-load: ocimem_a with addr=0x10, [34]=1 -> MonDReg=0xCAFEF00D, monitor_ready rises exactly 2 cycles after the pulse; then no_action -> reads 0x11, MonAReg=0x12.
- Wrap: ocimem_a with addr=0xFF, then ocimem_b -> MonAReg=0x00.
- Conflict: CPU read held while an ocimem_b pulse arrives -> waitrequest stays 1 until the JTAG write completes; the CPU read then returns the new data with 1 wait state.
- Errors: ocimem_a and no_action pulsed in the same cycle -> monitor_error=1, only the address load occurs; then ocimem_a with [35]=1 -> monitor_error=0.
- Reset mid-read: reset_n low during DRD -> MonDReg=0, monitor_ready=INIT_READY, FSM in IDLE; RAM[0x10] retains 0xCAFEF00D.
